addr_decode_ws: RTL and testbench
=================================

# addr_decode_ws

Parametrised, registered address decoder with per-region wait-state generation for the CPLD glue logic. It samples the upper CPU address bits when a bus cycle starts and asserts exactly one active-low chip select, chosen from a table of base/mask regions. It holds the select for a programmable number of wait cycles, then pulses `ack`. It supersedes the fixed combinational decoder and lets slow ROM/PIA devices share the bus with fast RAM.

## Interface
- `ADDR_W`, 4: number of decoded upper address bits (A15 downward).
- `NUM_CS`, 6: number of chip-select regions.
- `WAIT_W`, 3: width of each wait-count field and of the internal counter.
- `CS_BASE`, 24'hC8FED0: packed region bases, ADDR_W bits per region, cs0 in the LSBs.
- `CS_MASK`, 24'hFCFFF8: packed region masks; a 1 bit is compared, a 0 bit is don't-care.
- `CS_WAIT`, 18'h38210: packed wait counts, WAIT_W bits per region. Default waits: cs0=0, cs1=2, cs2=0, cs3=1, cs4=0, cs5=7.

Ports:
- `clk`, input, 1: system clock. All state updates on the rising edge.
- `rst_n`, input, 1: reset. Asynchronous and active-low.
- `addr`, input, ADDR_W: upper address bits. Sampled only on `start`.
- `start`, input, 1: one-cycle pulse marking the beginning of a bus cycle.
- `cs_n`, output, NUM_CS: registered active-low chip selects. At most one bit is low.
- `ack`, output, 1: one-cycle pulse marking the end of the access.
- `busy`, output, 1: high from the cycle after `start` through the `ack` cycle.
- `fault`, output, 1: sticky unmapped-access flag. Present only with the macro.
- `fault_clr`, input, 1: synchronous clear for `fault`. Present only with the macro.

## Operation
- Reset values: `cs_n` = all ones, `ack` = 0, `busy` = 0, `fault` = 0, state = IDLE, counter = 0.
- Match rule: region i matches when `(addr & MASK_i) == (BASE_i & MASK_i)`. When regions overlap, the lowest index wins. If no region matches, the access is unmapped.
- State machine:
  - IDLE: on `start`, latch the winning index and load counter = WAIT_i. Next state is WAIT if WAIT_i != 0, otherwise ACK. An unmapped access goes to ACK with all `cs_n` high.
  - WAIT: the selected `cs_n` is low and `ack` is 0. The counter decrements once per cycle. When the counter reaches 1, the next state is ACK.
  - ACK: the selected `cs_n` is still low and `ack` = 1 for exactly one cycle. Next state is IDLE, and all `cs_n` go high on the following edge.
- `start` is ignored outside IDLE. No queueing, and the ignored pulse produces no side effect.
- `addr` changes outside the IDLE+`start` cycle have no effect.
- A WAIT_i at its maximum value (2^WAIT_W−1) is legal. There is no wrap-around.
- Assertion of `rst_n` in any state immediately (asynchronously) forces the reset values and aborts the access; no `ack` is produced.

## Timing
- `start` is sampled at edge T.
- `cs_n` select is low from T+1 through the ACK cycle.
- `ack` is high during cycle T+1+WAIT_i.
- `cs_n` returns high and `busy` falls at T+2+WAIT_i.
- The earliest accepted back-to-back `start` is in cycle T+2+WAIT_i, the first IDLE cycle.
- Unmapped access: `ack` at T+1, `cs_n` never asserted.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `ADDR_DECODE_WS_FAULT_EN`.
- Defined:
  - `fault` and `fault_clr` ports exist.
  - `fault` is set at the edge that accepts an unmapped `start` and holds until `fault_clr` is sampled high.
  - If set and clear happen in the same cycle, set wins.
- Undefined:
  - Neither port exists.
  - Unmapped accesses still complete with an `ack` at T+1 and no select.

## Test plan
- Defaults, `addr`=4'h3, `start` at T: `cs_n`=6'b111110 and `ack`=1 at T+1; `cs_n`=6'b111111 at T+2.
- Defaults, `addr`=4'hD: `cs_n`=6'b111101 from T+1; `ack` at T+3 only; `busy` low at T+4.
- Defaults, `addr`=4'hC (7 waits): `ack` at T+8; a second `start` at T+4 with `addr`=4'h0 is ignored, and a `start` at T+9 is accepted.
- Reset mid-wait: `addr`=4'hC, `rst_n` low at T+3 → `cs_n`=all ones and `busy`=0 immediately, and no `ack` through T+10.
- With `ADDR_DECODE_WS_FAULT_EN` and CS_MASK overridden to 24'hFCFFFF, `addr`=4'h5: no select, `ack` at T+1, `fault`=1 until `fault_clr`; a simultaneous new fault and clear leaves `fault`=1.
- Overlap priority, NUM_CS=2, CS_BASE=8'h00, CS_MASK=8'h08, `addr`=4'h1: only cs0 is low.

Source files
------------

// File: rtl/addr_decode_ws.sv
// Registered base/mask address decoder with per-region wait states; one active-low select, then a one-cycle ack.
// Optional sticky unmapped-access flag (fault/fault_clr) is built when ADDR_DECODE_WS_FAULT_EN is defined.
module addr_decode_ws #(
  parameter int ADDR_W = 4,
  parameter int NUM_CS = 6,
  parameter int WAIT_W = 3,
  parameter logic [NUM_CS*ADDR_W-1:0] CS_BASE = 24'hC8FED0,
  parameter logic [NUM_CS*ADDR_W-1:0] CS_MASK = 24'hFCFFF8,
  parameter logic [NUM_CS*WAIT_W-1:0] CS_WAIT = 18'h38210
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic              start,
`ifdef ADDR_DECODE_WS_FAULT_EN
  input  logic              fault_clr,
  output logic              fault,
`endif
  output logic [NUM_CS-1:0] cs_n,
  output logic              ack,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
  logic                ack_q, ack_d;
  logic                busy_q, busy_d;
  logic                hit;
  logic [NUM_CS-1:0]   sel_oh;
  logic [WAIT_W-1:0]   wait_sel;
  logic                accept;

  assign accept = (state_q == S_IDLE) && start;

  // Scan from the top so the lowest matching index is the last one written and wins.
  always_comb begin
    hit      = 1'b0;
    sel_oh   = '0;
    wait_sel = '0;
    for (int i = NUM_CS - 1; i >= 0; i--) begin
      if ((addr & CS_MASK[i*ADDR_W +: ADDR_W]) ==
          (CS_BASE[i*ADDR_W +: ADDR_W] & CS_MASK[i*ADDR_W +: ADDR_W])) begin
        hit       = 1'b1;
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
        wait_sel  = CS_WAIT[i*WAIT_W +: WAIT_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cs_n_q  <= '1;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cs_n_q  <= cs_n_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d   = hit ? wait_sel : '0;
          state_d = (hit && (wait_sel != '0)) ? S_WAIT : S_ACK;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - WAIT_W'(1);
        if (cnt_q == WAIT_W'(1)) state_d = S_ACK;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state and registered, so nothing reaches a pin combinationally.
  always_comb begin
    ack_d  = (state_d == S_ACK);
    busy_d = (state_d != S_IDLE);
    cs_n_d = cs_n_q;
    if (accept)                 cs_n_d = hit ? ~sel_oh : '1;
    else if (state_d == S_IDLE) cs_n_d = '1;
  end

  assign cs_n = cs_n_q;
  assign ack  = ack_q;
  assign busy = busy_q;

`ifdef ADDR_DECODE_WS_FAULT_EN
  logic fault_q, fault_d;

  always_comb begin
    fault_d = fault_q;
    if (fault_clr)     fault_d = 1'b0;
    if (accept && !hit) fault_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= fault_d;
  end

  assign fault = fault_q;
`endif

endmodule

// File: tb/tb_addr_decode_ws.sv
module tb_addr_decode_ws;

  typedef struct {
    logic [3:0] addr;
    logic [5:0] cs_n;
    int         waits;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] addr = 4'h0;
  logic       start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [5:0] cs_n_a, cs_n_c;
  logic [1:0] cs_n_b;
  logic       ack_a, ack_b, ack_c, busy_a, busy_b, busy_c;
`ifdef ADDR_DECODE_WS_FAULT_EN
  logic       fault_a, fault_b, fault_c;
  logic       fault_clr_c = 1'b0;
`endif

  int   tests = 0;
  int   fails = 0;
  vec_t vecs[10];
  vec_t sb[$];

  always #5 clk = ~clk;

  addr_decode_ws dut_a (
    .clk(clk), .rst_n(rst_n), .addr(addr), .start(start_a),
`ifdef ADDR_DECODE_WS_FAULT_EN
    .fault_clr(1'b0), .fault(fault_a),
`endif
    .cs_n(cs_n_a), .ack(ack_a), .busy(busy_a)
  );

  addr_decode_ws #(.NUM_CS(2), .CS_BASE(8'h00), .CS_MASK(8'h08), .CS_WAIT(6'h00)) dut_b (
    .clk(clk), .rst_n(rst_n), .addr(addr), .start(start_b),
`ifdef ADDR_DECODE_WS_FAULT_EN
    .fault_clr(1'b0), .fault(fault_b),
`endif
    .cs_n(cs_n_b), .ack(ack_b), .busy(busy_b)
  );

  addr_decode_ws #(.CS_MASK(24'hFCFFFF)) dut_c (
    .clk(clk), .rst_n(rst_n), .addr(addr), .start(start_c),
`ifdef ADDR_DECODE_WS_FAULT_EN
    .fault_clr(fault_clr_c), .fault(fault_c),
`endif
    .cs_n(cs_n_c), .ack(ack_c), .busy(busy_c)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one access on dut_a; the expected record goes into the scoreboard and is popped at ack.
  task automatic access_a(input vec_t v);
    vec_t e;
    int   n;
    @(negedge clk);
    addr    = v.addr;
    start_a = 1'b1;
    sb.push_back(v);
    @(negedge clk);
    start_a = 1'b0;
    n = 1;
    check("cs_first_cycle", 32'(cs_n_a), 32'(v.cs_n));
    check("busy_first_cycle", 32'(busy_a), 32'd1);
    while (!ack_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    check("ack_latency", n, e.waits + 1);
    check("cs_at_ack", 32'(cs_n_a), 32'(e.cs_n));
    @(negedge clk);
    check("cs_release", 32'(cs_n_a), 32'h3F);
    check("busy_fall", 32'(busy_a), 32'd0);
    check("ack_one_cycle", 32'(ack_a), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    logic seen;

    vecs[0] = '{4'h3, 6'b111110, 0};
    vecs[1] = '{4'hD, 6'b111101, 2};
    vecs[2] = '{4'hE, 6'b111011, 0};
    vecs[3] = '{4'hF, 6'b110111, 1};
    vecs[4] = '{4'h8, 6'b101111, 0};
    vecs[5] = '{4'hC, 6'b011111, 7};
    vecs[6] = '{4'h0, 6'b111110, 0};
    vecs[7] = '{4'hB, 6'b101111, 0};
    vecs[8] = '{4'h7, 6'b111110, 0};
    vecs[9] = '{4'hD, 6'b111101, 2};

    repeat (2) @(negedge clk);
    check("reset_cs", 32'(cs_n_a), 32'h3F);
    check("reset_ack", 32'(ack_a), 32'd0);
    check("reset_busy", 32'(busy_a), 32'd0);
`ifdef ADDR_DECODE_WS_FAULT_EN
    check("reset_fault", 32'(fault_c), 32'd0);
`endif
    rst_n = 1'b1;

    foreach (vecs[i]) access_a(vecs[i]);

    // Start ignored while busy, then accepted in the first IDLE cycle.
    @(negedge clk);
    addr = 4'hC; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; n = 1;
    repeat (3) begin @(negedge clk); n++; end
    addr = 4'h0; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; n++;
    check("ignored_start_cs", 32'(cs_n_a), 32'h1F);
    while (!ack_a && n < 20) begin @(negedge clk); n++; end
    check("busy_ack_latency", n, 8);
    check("busy_ack_cs", 32'(cs_n_a), 32'h1F);
    @(negedge clk);
    check("b2b_idle_busy", 32'(busy_a), 32'd0);
    addr = 4'h3; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("b2b_cs", 32'(cs_n_a), 32'h3E);
    check("b2b_ack", 32'(ack_a), 32'd1);
    @(negedge clk);
    check("b2b_release", 32'(cs_n_a), 32'h3F);

    // Asynchronous reset in the middle of the 7-cycle wait.
    @(negedge clk);
    addr = 4'hC; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_cs", 32'(cs_n_a), 32'h3F);
    check("rst_mid_busy", 32'(busy_a), 32'd0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      rst_n = 1'b1;
      if (ack_a) seen = 1'b1;
    end
    check("rst_no_ack", 32'(seen), 32'd0);

    // Unmapped access with the narrowed cs0 mask.
    @(negedge clk);
    addr = 4'h5; start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    check("unmapped_cs", 32'(cs_n_c), 32'h3F);
    check("unmapped_ack", 32'(ack_c), 32'd1);
`ifdef ADDR_DECODE_WS_FAULT_EN
    check("fault_set", 32'(fault_c), 32'd1);
`endif
    @(negedge clk);
    check("unmapped_ack_done", 32'(ack_c), 32'd0);
    check("unmapped_busy_fall", 32'(busy_c), 32'd0);
`ifdef ADDR_DECODE_WS_FAULT_EN
    repeat (3) @(negedge clk);
    check("fault_sticky", 32'(fault_c), 32'd1);
    fault_clr_c = 1'b1;
    @(negedge clk);
    fault_clr_c = 1'b0;
    check("fault_clear", 32'(fault_c), 32'd0);
    addr = 4'h5; start_c = 1'b1; fault_clr_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0; fault_clr_c = 1'b0;
    check("fault_set_wins", 32'(fault_c), 32'd1);
    @(negedge clk);
    check("fault_a_clean", 32'(fault_a), 32'd0);
    check("fault_b_clean", 32'(fault_b), 32'd0);
`endif

    // Overlapping regions: lowest index takes priority.
    @(negedge clk);
    addr = 4'h1; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check("overlap_cs", 32'(cs_n_b), 32'h2);
    check("overlap_ack", 32'(ack_b), 32'd1);
    @(negedge clk);
    check("overlap_release", 32'(cs_n_b), 32'h3);
    check("overlap_busy", 32'(busy_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
